// File: rtl/cvxif_offload_master.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_offload_master
// Purpose  : Core-side initiator for the simplified CVXIF of the posit
//            coprocessor. Takes one custom-3 instruction with its operands,
//            runs issue -> register -> result, and hands the result to the
//            core writeback port. One transaction in flight at a time.
// Ports    : clk/rst_n                 clock, async active-low reset
//            core_valid_i/core_ready_o instruction + rs1/rs2 from the core
//            core_illegal_o/core_done_o/core_timeout_o  1-cycle status pulses
//            wb_valid_o/wb_ready_i     writeback of rd/data to the core
//            issue_*                   issue handshake and response
//            register_*                operand handshake (registered)
//            result_*                  result handshake
// Options  : CVXIF_OFFLOAD_TIMEOUT_EN  bounds the result wait to TIMEOUT_CYCLES
// Revision : 1.0  initial release
// ============================================================================
module cvxif_offload_master #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 core_valid_i,
    output logic                 core_ready_o,
    input  logic [31:0]          core_instr_i,
    input  logic [XLEN-1:0]      core_rs1_i,
    input  logic [XLEN-1:0]      core_rs2_i,
    output logic                 core_illegal_o,
    output logic                 core_done_o,
    output logic                 core_timeout_o,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [4:0]           wb_rd_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [31:0]          issue_req_instr_o,
    input  logic                 issue_resp_accept_i,
    input  logic                 issue_resp_writeback_i,
    input  logic [1:0]           issue_resp_register_read_i,
    output logic                 register_valid_o,
    input  logic                 register_ready_i,
    output logic [1:0][XLEN-1:0] register_rs_o,
    output logic [1:0]           register_rs_valid_o,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    input  logic [XLEN-1:0]      result_data_i
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_REGS  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_WB    = 3'd4;

    logic [2:0]           state_q,  state_d;
    logic [31:0]          instr_q,  instr_d;
    logic [XLEN-1:0]      rs1_q,    rs1_d;
    logic [XLEN-1:0]      rs2_q,    rs2_d;
    logic [1:0]           rr_q,     rr_d;
    logic                 wbreq_q,  wbreq_d;
    logic [1:0][XLEN-1:0] rsout_q,  rsout_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 illegal_q, illegal_d;
    logic                 done_q,    done_d;
    // Coprocessor-facing valid/ready flops, loaded from the next state so
    // they line up exactly with the state they belong to.
    logic                 issue_valid_q;
    logic                 register_valid_q;
    logic                 result_ready_q;

`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
    localparam int unsigned            c_CNT_W    = 16;
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0]                cnt_q, cnt_d;
    logic                              timeout_q, timeout_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // State register (plus datapath and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= c_ST_IDLE;
            instr_q          <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            rr_q             <= '0;
            wbreq_q          <= 1'b0;
            rsout_q          <= '0;
            result_q         <= '0;
            illegal_q        <= 1'b0;
            done_q           <= 1'b0;
            issue_valid_q    <= 1'b0;
            register_valid_q <= 1'b0;
            result_ready_q   <= 1'b0;
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
            cnt_q            <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            instr_q          <= instr_d;
            rs1_q            <= rs1_d;
            rs2_q            <= rs2_d;
            rr_q             <= rr_d;
            wbreq_q          <= wbreq_d;
            rsout_q          <= rsout_d;
            result_q         <= result_d;
            illegal_q        <= illegal_d;
            done_q           <= done_d;
            issue_valid_q    <= (state_d == c_ST_ISSUE);
            register_valid_q <= (state_d == c_ST_REGS);
            result_ready_q   <= (state_d == c_ST_WAIT);
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
            cnt_q            <= cnt_d;
            timeout_q        <= timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rr_d      = rr_q;
        wbreq_d   = wbreq_q;
        rsout_d   = rsout_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        done_d    = 1'b0;
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
        timeout_d = 1'b0;
        // Zero on every cycle outside WAIT so it starts from 0 on entry.
        cnt_d     = (state_q == c_ST_WAIT) ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (core_valid_i) begin
                    instr_d = core_instr_i;
                    rs1_d   = core_rs1_i;
                    rs2_d   = core_rs2_i;
                    state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                // issue_valid is high for the whole ISSUE state, so
                // issue_ready alone marks the handshake.
                if (issue_ready_i) begin
                    if (!issue_resp_accept_i) begin
                        illegal_d = 1'b1;
                        state_d   = c_ST_IDLE;
                    end else begin
                        rr_d       = issue_resp_register_read_i;
                        wbreq_d    = issue_resp_writeback_i;
                        // Unrequested operand slots are presented as zero.
                        rsout_d[0] = issue_resp_register_read_i[0] ? rs1_q : '0;
                        rsout_d[1] = issue_resp_register_read_i[1] ? rs2_q : '0;
                        if (issue_resp_register_read_i != 2'b00) begin
                            state_d = c_ST_REGS;
                        end else if (issue_resp_writeback_i) begin
                            state_d = c_ST_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = c_ST_IDLE;
                        end
                    end
                end
            end
            c_ST_REGS: begin
                if (register_ready_i) begin
                    if (wbreq_q) begin
                        state_d = c_ST_WAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = c_ST_IDLE;
                    end
                end
            end
            c_ST_WAIT: begin
                // A result arriving in the expiry cycle wins over the timeout.
                if (result_valid_i) begin
                    result_d = result_data_i;
                    state_d  = c_ST_WB;
                end
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
                else if (cnt_q == c_CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = c_ST_IDLE;
                end
`endif
            end
            c_ST_WB: begin
                if (wb_ready_i) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        core_ready_o        = (state_q == c_ST_IDLE);
        wb_valid_o          = (state_q == c_ST_WB);
        wb_rd_o             = instr_q[11:7];
        wb_data_o           = result_q;
        core_illegal_o      = illegal_q;
        core_done_o         = done_q;
        issue_valid_o       = issue_valid_q;
        issue_req_instr_o   = instr_q;
        register_valid_o    = register_valid_q;
        register_rs_o       = rsout_q;
        register_rs_valid_o = rr_q;
        result_ready_o      = result_ready_q;
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
        core_timeout_o      = timeout_q;
`else
        core_timeout_o      = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_offload_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_offload_master
// Purpose  : Self-checking bench for cvxif_offload_master. Each transaction
//            is described by its operands, coprocessor response and stall
//            lengths; a timeline model derives the expected outputs of every
//            cycle, and one compare process checks the DUT against it.
//            Directed cases pin literal values, reset and the result wait.
// Revision : 1.0  initial release
// ============================================================================
module tb_cvxif_offload_master;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_valid, core_ready;
    logic [31:0]       core_instr, core_rs1, core_rs2;
    logic              core_illegal, core_done, core_timeout;
    logic              wb_valid, wb_ready;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              issue_valid, issue_ready;
    logic [31:0]       issue_req_instr;
    logic              accept, wbresp;
    logic [1:0]        rr;
    logic              register_valid, register_ready;
    logic [1:0][31:0]  register_rs;
    logic [1:0]        register_rs_valid;
    logic              result_valid, result_ready;
    logic [31:0]       result_data;

    always #5 clk = ~clk;

    cvxif_offload_master #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .core_valid_i               (core_valid),
        .core_ready_o               (core_ready),
        .core_instr_i               (core_instr),
        .core_rs1_i                 (core_rs1),
        .core_rs2_i                 (core_rs2),
        .core_illegal_o             (core_illegal),
        .core_done_o                (core_done),
        .core_timeout_o             (core_timeout),
        .wb_valid_o                 (wb_valid),
        .wb_ready_i                 (wb_ready),
        .wb_rd_o                    (wb_rd),
        .wb_data_o                  (wb_data),
        .issue_valid_o              (issue_valid),
        .issue_ready_i              (issue_ready),
        .issue_req_instr_o          (issue_req_instr),
        .issue_resp_accept_i        (accept),
        .issue_resp_writeback_i     (wbresp),
        .issue_resp_register_read_i (rr),
        .register_valid_o           (register_valid),
        .register_ready_i           (register_ready),
        .register_rs_o              (register_rs),
        .register_rs_valid_o        (register_rs_valid),
        .result_valid_i             (result_valid),
        .result_ready_o             (result_ready),
        .result_data_i              (result_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Current transaction description
    logic [31:0] t_instr, t_rs1, t_rs2, t_res;
    logic        t_acc, t_wb;
    logic [1:0]  t_rr;
    int          si, sr, sres, swb;

    // Model expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        pend_ill = 1'b0, pend_done = 1'b0;
    logic        e_cr, e_ill, e_done, e_iv, e_rv, e_resr, e_wbv;
    logic [31:0] e_instr, e_wbd;
    logic [63:0] e_rs;
    logic [1:0]  e_rsv;
    logic [4:0]  e_rd;

    always @(negedge clk) begin
        if (chk_en) begin
            check("core_ready",     core_ready,     e_cr);
            check("core_illegal",   core_illegal,   e_ill);
            check("core_done",      core_done,      e_done);
            check("core_timeout",   core_timeout,   1'b0);
            check("issue_valid",    issue_valid,    e_iv);
            check("register_valid", register_valid, e_rv);
            check("result_ready",   result_ready,   e_resr);
            check("wb_valid",       wb_valid,       e_wbv);
            if (e_iv) check("issue_req_instr", issue_req_instr, e_instr);
            if (e_rv) begin
                check("register_rs",       register_rs,       e_rs);
                check("register_rs_valid", register_rs_valid, e_rsv);
            end
            if (e_wbv) begin
                check("wb_rd",   wb_rd,   e_rd);
                check("wb_data", wb_data, e_wbd);
            end
        end
    end

    task automatic clear_inputs();
        core_valid = 0; core_instr = 0; core_rs1 = 0; core_rs2 = 0;
        issue_ready = 0; accept = 0; wbresp = 0; rr = 0;
        register_ready = 0; result_valid = 0; result_data = 0; wb_ready = 0;
    endtask

    // Junk on every input; the phase that owns a handshake overrides it.
    task automatic junk_inputs();
        core_valid     = 1'($urandom);
        core_instr     = $urandom; core_rs1 = $urandom; core_rs2 = $urandom;
        issue_ready    = 1'($urandom); accept = 1'($urandom);
        wbresp         = 1'($urandom); rr = 2'($urandom);
        register_ready = 1'($urandom); result_valid = 1'($urandom);
        result_data    = $urandom; wb_ready = 1'($urandom);
    endtask

    task automatic gap_cycle();
        @(posedge clk); #1;
        junk_inputs();
        core_valid = 1'b0;
        e_cr = 1; e_ill = pend_ill; e_done = pend_done;
        pend_ill = 0; pend_done = 0;
        e_iv = 0; e_rv = 0; e_resr = 0; e_wbv = 0;
        chk_en = 1;
        @(negedge clk);
    endtask

    // Runs one transaction from the core handshake (cycle 0) up to the
    // cycle before the master is idle again; any status pulse is left
    // pending for the following cycle.
    task automatic run_txn(input int tag);
        int iss_e, reg_s, reg_e, wt_s, wt_e, wb_s, wb_e, nxt, e_end;
        iss_e = 1 + si;
        reg_s = 1; reg_e = 0; wt_s = 1; wt_e = 0; wb_s = 1; wb_e = 0;
        nxt = iss_e + 1;
        if (t_acc) begin
            if (t_rr != 2'b00) begin reg_s = nxt; reg_e = nxt + sr; nxt = reg_e + 1; end
            if (t_wb) begin
                wt_s = nxt; wt_e = nxt + sres; wb_s = wt_e + 1; wb_e = wb_s + swb; nxt = wb_e + 1;
            end
        end
        e_end = nxt;
        for (int c = 0; c < e_end; c++) begin
            @(posedge clk); #1;
            junk_inputs();
            if (c == 0) begin
                core_valid = 1; core_instr = t_instr; core_rs1 = t_rs1; core_rs2 = t_rs2;
            end
            if (c >= 1 && c <= iss_e) issue_ready = (c == iss_e);
            if (c == iss_e) begin accept = t_acc; wbresp = t_wb; rr = t_rr; end
            if (c >= reg_s && c <= reg_e) register_ready = (c == reg_e);
            if (c >= wt_s && c <= wt_e) begin
                result_valid = (c == wt_e);
                if (c == wt_e) result_data = t_res;
            end
            if (c >= wb_s && c <= wb_e) wb_ready = (c == wb_e);
            e_cr    = (c == 0);
            e_ill   = pend_ill; e_done = pend_done; pend_ill = 0; pend_done = 0;
            e_iv    = (c >= 1 && c <= iss_e);
            e_rv    = (c >= reg_s && c <= reg_e);
            e_resr  = (c >= wt_s && c <= wt_e);
            e_wbv   = (c >= wb_s && c <= wb_e);
            e_instr = t_instr;
            e_rs    = {(t_rr[1] ? t_rs2 : 32'h0), (t_rr[0] ? t_rs1 : 32'h0)};
            e_rsv   = t_rr;
            e_rd    = t_instr[11:7];
            e_wbd   = t_res;
            chk_en  = 1;
            @(negedge clk);
            if (tag == 1 && c == 2) begin
                check("t1_rs_valid", register_rs_valid, 2'b11);
                check("t1_rs",       register_rs,       64'h40000000_40000000);
            end
            if (tag == 1 && c == 3) check("t1_wb_early", wb_valid, 1'b0);
            if (tag == 1 && c == 4) begin
                check("t1_wb_valid", wb_valid, 1'b1);
                check("t1_wb_rd",    wb_rd,    5'd10);
                check("t1_wb_data",  wb_data,  32'h48000000);
            end
            if (tag == 4 && c == 2) begin
                check("t4_rs_valid", register_rs_valid, 2'b01);
                check("t4_rs2_zero", register_rs[1],    32'h0);
            end
        end
        pend_ill  = !t_acc;
        pend_done = t_acc && !t_wb;
    endtask

    task automatic set_txn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic acc, input logic wbr, input logic [1:0] r,
                           input int s0, input int s1, input int s2, input int s3);
        t_instr = ins; t_rs1 = a; t_rs2 = b; t_res = res;
        t_acc = acc; t_wb = wbr; t_rr = r;
        si = s0; sr = s1; sres = s2; swb = s3;
    endtask

    int  n_rr, to_at;
    logic saw_to, last_rr, last_cr;

    initial begin
        rst_n = 0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_ready",  core_ready,      1'b1);
        check("rst_issue_valid", issue_valid,     1'b0);
        check("rst_reg_valid",   register_valid,  1'b0);
        check("rst_result_rdy",  result_ready,    1'b0);
        check("rst_wb_valid",    wb_valid,        1'b0);
        check("rst_pulses",      {core_illegal, core_done, core_timeout}, 3'b000);
        check("rst_wb_data",     wb_data,         32'h0);
        check("rst_instr",       issue_req_instr, 32'h0);
        rst_n = 1;

        // Plain add, no stalls.
        set_txn(32'h0020857B, 32'h40000000, 32'h40000000, 32'h48000000, 1, 1, 2'b11, 0, 0, 0, 0);
        run_txn(1);
        gap_cycle();

        // Rejected instruction.
        set_txn(32'h1234567B, 32'h1, 32'h2, 32'h0, 0, 1, 2'b11, 0, 0, 0, 0);
        run_txn(0);
        gap_cycle();
        check("t2_illegal",    core_illegal, 1'b1);
        check("t2_core_ready", core_ready,   1'b1);
        gap_cycle();
        check("t2_illegal_1cyc", core_illegal, 1'b0);

        // Stalls on every handshake.
        set_txn(32'h00A3C5FB, 32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF, 1, 1, 2'b11, 3, 2, 5, 2);
        run_txn(0);

        // rs1 only, then a writeback-free, operand-free instruction back-to-back.
        set_txn(32'h00B1C2FB, 32'hAAAA5555, 32'hFFFFFFFF, 32'h2468ACE0, 1, 1, 2'b01, 0, 0, 0, 0);
        run_txn(4);
        set_txn(32'h0000007B, 32'h11111111, 32'h22222222, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0);
        run_txn(0);
        gap_cycle();
        check("t4_done", core_done, 1'b1);

        // Randomized traffic, mostly back-to-back.
        for (int k = 0; k < 200; k++) begin
            set_txn($urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom_range(0, 3));
            run_txn(0);
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < $urandom_range(1, 3); g++) gap_cycle();
            end
        end
        gap_cycle();
        chk_en = 0;

        // Reset while waiting for the result.
        @(posedge clk); #1; clear_inputs();
        core_valid = 1; core_instr = 32'h0020857B; core_rs1 = 32'h5; core_rs2 = 32'h6;
        @(posedge clk); #1; clear_inputs(); issue_ready = 1; accept = 1; wbresp = 1; rr = 2'b11;
        @(posedge clk); #1; clear_inputs(); register_ready = 1;
        @(posedge clk); #1; clear_inputs();
        @(negedge clk);
        check("t5_in_wait", result_ready, 1'b1);
        #1 rst_n = 0;
        #1;
        check("t5_core_ready",   core_ready,        1'b1);
        check("t5_result_ready", result_ready,      1'b0);
        check("t5_valids",       {issue_valid, register_valid, wb_valid}, 3'b000);
        check("t5_rs_valid",     register_rs_valid, 2'b00);
        check("t5_rs",           register_rs,       64'h0);
        check("t5_instr",        issue_req_instr,   32'h0);
        @(posedge clk); #2 rst_n = 1;
        result_valid = 1; result_data = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_late_result_wb", wb_valid,   1'b0);
            check("t5_late_result_cr", core_ready, 1'b1);
            @(posedge clk); #1;
        end
        clear_inputs();

        // Result never arrives.
        @(posedge clk); #1; clear_inputs(); core_valid = 1; core_instr = 32'h00000D7B;
        @(posedge clk); #1; clear_inputs(); issue_ready = 1; accept = 1; wbresp = 1; rr = 2'b00;
        @(posedge clk); #1; clear_inputs();
        n_rr = 0; saw_to = 0; to_at = -1; last_rr = 0; last_cr = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (result_ready) n_rr++;
            if (core_timeout && !saw_to) begin saw_to = 1; to_at = k; end
            last_rr = result_ready;
            last_cr = core_ready;
            @(posedge clk); #1;
        end
`ifdef CVXIF_OFFLOAD_TIMEOUT_EN
        check("t6_wait_cycles", n_rr,    8);
        check("t6_timeout",     saw_to,  1'b1);
        check("t6_timeout_at",  to_at,   8);
        check("t6_idle",        last_cr, 1'b1);
`else
        check("t6_wait_cycles", n_rr,    1000);
        check("t6_no_timeout",  saw_to,  1'b0);
        check("t6_still_wait",  last_rr, 1'b1);
        check("t6_not_ready",   last_cr, 1'b0);
        result_valid = 1; result_data = 32'hCAFE0001;
        @(negedge clk);
        @(posedge clk); #1; clear_inputs(); wb_ready = 1;
        @(negedge clk);
        check("t6_wb_valid", wb_valid, 1'b1);
        check("t6_wb_data",  wb_data,  32'hCAFE0001);
        check("t6_wb_rd",    wb_rd,    5'd26);
        @(posedge clk); #1; clear_inputs();
        @(negedge clk);
        check("t6_idle", core_ready, 1'b1);
        check("t6_wb_done", wb_valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
